// File: rtl/fma_op_sequencer.sv
// Operand issuer / result collector for the BF16 FMA: walks a DEPTH-entry operand
// table, hands each {A,B,C} triple to the FMA and records its result and flags.
module fma_op_sequencer #(
    parameter int DEPTH   = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic [AW-1:0] tbl_addr,
    input  logic [47:0]   tbl_data,
    output logic          op_valid,
    input  logic          op_ready,
    output logic [15:0]   op_a,
    output logic [15:0]   op_b,
    output logic [15:0]   op_c,
    input  logic          res_valid,
    input  logic [15:0]   res,
    input  logic [6:0]    flags,
    output logic [15:0]   last_res,
    output logic [6:0]    last_flags,
    output logic [6:0]    flag_accum,
    output logic [AW:0]   res_cnt,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
    localparam logic [7:0]    TO_LIM   = 8'(TIMEOUT);

    state_e        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   op_a_q, op_a_d, op_b_q, op_b_d, op_c_q, op_c_d;
    logic [15:0]   last_res_q, last_res_d;
    logic [6:0]    last_flags_q, last_flags_d;
    logic [6:0]    flag_accum_q, flag_accum_d;
    logic [AW:0]   res_cnt_q, res_cnt_d;
    logic          timeout_q, timeout_d;
    logic [7:0]    wd_q, wd_d, wd_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Operand handshake: op_valid rises in ISSUE and stays high with op_a/b/c frozen
    // until the cycle op_ready is also high; that cycle is the single transfer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_FETCH;
            S_FETCH: state_d = S_LOAD;
            S_LOAD:  state_d = S_ISSUE;
            S_ISSUE: if (op_ready) state_d = S_WAIT;
            S_WAIT: begin
                if (res_valid)            state_d = (idx_q == LAST_IDX) ? S_DONE : S_FETCH;
                else if (wd_inc == TO_LIM) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != S_IDLE);
        op_valid  = (state_q == S_ISSUE);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // The table index doubles as the address register, so it only moves on entry to FETCH.
    always_comb begin
        idx_d        = idx_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_c_d       = op_c_q;
        last_res_d   = last_res_q;
        last_flags_d = last_flags_q;
        flag_accum_d = flag_accum_q;
        res_cnt_d    = res_cnt_q;
        timeout_d    = timeout_q;
        wd_d         = wd_q;
        wd_inc       = wd_q + 8'd1;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    idx_d        = '0;
                    flag_accum_d = '0;
                    res_cnt_d    = '0;
                    timeout_d    = 1'b0;
                end
            end
            S_LOAD: begin
                op_a_d = tbl_data[47:32];
                op_b_d = tbl_data[31:16];
                op_c_d = tbl_data[15:0];
            end
            S_ISSUE: begin
                if (op_ready) wd_d = '0;
            end
            S_WAIT: begin
                if (res_valid) begin
                    last_res_d   = res;
                    last_flags_d = flags;
                    flag_accum_d = flag_accum_q | flags;
                    res_cnt_d    = res_cnt_q + (AW+1)'(1);
                    if (idx_q != LAST_IDX) idx_d = idx_q + AW'(1);
                end else begin
                    wd_d = wd_inc;
                    if (wd_inc == TO_LIM) timeout_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q        <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_c_q       <= '0;
            last_res_q   <= '0;
            last_flags_q <= '0;
            flag_accum_q <= '0;
            res_cnt_q    <= '0;
            timeout_q    <= 1'b0;
            wd_q         <= '0;
        end else begin
            idx_q        <= idx_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_c_q       <= op_c_d;
            last_res_q   <= last_res_d;
            last_flags_q <= last_flags_d;
            flag_accum_q <= flag_accum_d;
            res_cnt_q    <= res_cnt_d;
            timeout_q    <= timeout_d;
            wd_q         <= wd_d;
        end
    end

    assign tbl_addr   = idx_q;
    assign op_a       = op_a_q;
    assign op_b       = op_b_q;
    assign op_c       = op_c_q;
    assign last_res   = last_res_q;
    assign last_flags = last_flags_q;
    assign flag_accum = flag_accum_q;
    assign res_cnt    = res_cnt_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_fma_op_sequencer.sv
// Bench for fma_op_sequencer: a per-run timeline model of the expected outputs,
// an operand scoreboard checked at every handshake, plus literal spot checks.
module tb_fma_op_sequencer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam int TO    = 15;

  logic          clk, rst, start, op_ready, res_valid;
  logic [15:0]   res;
  logic [6:0]    flags;
  logic [47:0]   tbl_data;
  logic [AW-1:0] tbl_addr;
  logic          op_valid, busy, done, timeout;
  logic [15:0]   op_a, op_b, op_c, last_res;
  logic [6:0]    last_flags, flag_accum;
  logic [AW:0]   res_cnt;
  logic [2:0]    dbg_state;

  logic [47:0]   rom [DEPTH];
  logic [AW-1:0] addr_r = '0;
  int            w_a [DEPTH];
  int            l_a [DEPTH];
  logic [15:0]   rv_a [DEPTH];
  logic [6:0]    fl_a [DEPTH];

  logic [AW-1:0] e_addr;
  logic [47:0]   e_ops;
  logic          e_valid, e_busy, e_done, e_timeout;
  logic [15:0]   e_last_res;
  logic [6:0]    e_last_flags, e_accum;
  logic [AW:0]   e_cnt;
  bit            pend_cap, pend_to;
  logic [15:0]   pend_res;
  logic [6:0]    pend_fl;
  logic [47:0]   exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;
  int hs_cnt  = 0;

  fma_op_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .res_valid(res_valid), .res(res), .flags(flags), .last_res(last_res),
    .last_flags(last_flags), .flag_accum(flag_accum), .res_cnt(res_cnt), .busy(busy),
    .done(done), .timeout(timeout), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // operand ROM: data valid one cycle after the address
  always @(posedge clk) addr_r <= tbl_addr;
  assign tbl_data = rom[addr_r];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("op_valid", 64'(op_valid), 64'(e_valid));
    chk("tbl_addr", 64'(tbl_addr), 64'(e_addr));
    chk("operands", 64'({op_a, op_b, op_c}), 64'(e_ops));
    chk("last_res", 64'(last_res), 64'(e_last_res));
    chk("last_flags", 64'(last_flags), 64'(e_last_flags));
    chk("flag_accum", 64'(flag_accum), 64'(e_accum));
    chk("res_cnt", 64'(res_cnt), 64'(e_cnt));
    chk("timeout", 64'(timeout), 64'(e_timeout));
    if (done) done_cnt++;
    if (op_valid && op_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) chk("hs_unexpected", 64'(1), 64'(0));
      else chk("hs_ops", 64'({op_a, op_b, op_c}), 64'(exp_q.pop_front()));
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic noise(input bit spur);
    op_ready  = 1'($urandom_range(0, 1));
    res_valid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
    res       = 16'($urandom);
    flags     = 7'($urandom);
  endtask

  task automatic apply_pend();
    if (pend_cap) begin
      e_last_res   = pend_res;
      e_last_flags = pend_fl;
      e_accum      = e_accum | pend_fl;
      e_cnt        = e_cnt + (AW+1)'(1);
    end
    if (pend_to) e_timeout = 1'b1;
    pend_cap = 0;
    pend_to  = 0;
  endtask

  task automatic zero_model();
    e_addr = '0; e_ops = '0; e_valid = 0; e_busy = 0; e_done = 0; e_timeout = 0;
    e_last_res = '0; e_last_flags = '0; e_accum = '0; e_cnt = '0;
    pend_cap = 0; pend_to = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ops"}, 64'({op_a, op_b, op_c}), 64'(0));
    chk({tag, "_ctl"}, 64'({tbl_addr, op_valid, last_res, last_flags, flag_accum,
                            res_cnt, busy, done, timeout}), 64'(0));
  endtask

  task automatic set_cfg(input int w, input int l, input logic [15:0] rv, input logic [6:0] fl);
    for (int i = 0; i < DEPTH; i++) begin
      w_a[i] = w; l_a[i] = l; rv_a[i] = rv; fl_a[i] = fl;
    end
  endtask

  // One run laid out as a timeline: FETCH, LOAD, ISSUE for w+1 cycles, WAIT until result.
  task automatic run_seq(input bit spur, input int abort_entry);
    bit cap;
    step(); noise(spur); start = 1'b1; e_done = 0;
    for (int i = 0; i < DEPTH; i++) begin
      step(); apply_pend(); noise(spur); start = 1'($urandom_range(0, 1));
      if (spur) res_valid = 1'b1;
      e_busy = 1; e_valid = 0; e_addr = AW'(i);
      if (i == 0) begin e_cnt = '0; e_accum = '0; e_timeout = 0; end
      step(); noise(spur); start = 1'($urandom_range(0, 1));
      for (int k = 0; k <= w_a[i]; k++) begin
        step(); noise(spur); start = 1'($urandom_range(0, 1));
        op_ready = (k == w_a[i]);
        if (spur && k == w_a[i]) res_valid = 1'b1;
        e_valid = 1; e_ops = rom[i];
        if (k == w_a[i]) exp_q.push_back(rom[i]);
      end
      cap = 0;
      for (int j = 1; j <= TO; j++) begin
        step(); noise(1'b0); start = 1'($urandom_range(0, 1)); e_valid = 0;
        if (i == abort_entry) begin
          #2 rst = 1'b0;
          #1 chk_all_zero("async_rst");
          zero_model(); start = 1'b0;
          step(); step();
          rst = 1'b1;
          step(); step();
          return;
        end
        if (l_a[i] == j) begin
          res_valid = 1'b1; res = rv_a[i]; flags = fl_a[i];
          cap = 1; pend_cap = 1; pend_res = rv_a[i]; pend_fl = fl_a[i];
          break;
        end
      end
      if (!cap) begin
        pend_to = 1;
        break;
      end
    end
    step(); apply_pend(); noise(spur); start = 1'($urandom_range(0, 1));
    if (spur) res_valid = 1'b1;
    e_done = 1; e_valid = 0;
    step(); noise(spur); start = 1'b0; e_done = 0; e_busy = 0;
    repeat (2) begin step(); noise(spur); end
  endtask

  initial begin : main
    int d0, h0;
    rst = 1'b0; start = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res = '0; flags = '0;
    for (int i = 0; i < DEPTH; i++) rom[i] = '0;
    zero_model();
    repeat (3) step();
    chk_all_zero("reset");
    rst = 1'b1;
    step();

    // all entries {3F80,4000,3F80}, result 4040 two cycles after handshake
    for (int i = 0; i < DEPTH; i++) rom[i] = 48'h3F80_4000_3F80;
    set_cfg(0, 2, 16'h4040, 7'h00);
    d0 = done_cnt; h0 = hs_cnt;
    run_seq(0, -1);
    chk("basic_hs", 64'(hs_cnt - h0), 64'(4));
    chk("basic_cnt", 64'(res_cnt), 64'(4));
    chk("basic_last", 64'(last_res), 64'(16'h4040));
    chk("basic_accum", 64'(flag_accum), 64'(0));
    chk("basic_done", 64'(done_cnt - d0), 64'(1));
    chk("basic_busy", 64'(busy), 64'(0));

    // backpressure: op_ready low for 5 ISSUE cycles on entry 0
    for (int i = 0; i < DEPTH; i++) rom[i] = 48'({$urandom, $urandom});
    set_cfg(0, 1, 16'h1234, 7'h00);
    w_a[0] = 5;
    h0 = hs_cnt;
    run_seq(0, -1);
    chk("bp_hs", 64'(hs_cnt - h0), 64'(4));

    // flags: overflow on entry 1, qNaN on entry 2
    set_cfg(1, 3, 16'h3F80, 7'h00);
    fl_a[1] = 7'b0010000; fl_a[2] = 7'b0001000; rv_a[3] = 16'hC000;
    run_seq(0, -1);
    chk("flags_accum", 64'(flag_accum), 64'(7'b0011000));
    chk("flags_last", 64'(last_flags), 64'(0));
    chk("flags_last_res", 64'(last_res), 64'(16'hC000));

    // watchdog: no result on entry 0
    set_cfg(0, 0, 16'h0000, 7'h00);
    d0 = done_cnt;
    run_seq(0, -1);
    chk("to_flag", 64'(timeout), 64'(1));
    chk("to_cnt", 64'(res_cnt), 64'(0));
    chk("to_done", 64'(done_cnt - d0), 64'(1));
    set_cfg(0, TO, 16'hABCD, 7'h01);
    run_seq(0, -1);
    chk("to_cleared", 64'(timeout), 64'(0));
    chk("to_boundary_cnt", 64'(res_cnt), 64'(4));

    // spurious result pulses in ISSUE, handshake cycle and after capture
    set_cfg(1, 2, 16'h5555, 7'h02);
    run_seq(1, -1);
    chk("spur_cnt", 64'(res_cnt), 64'(4));
    chk("spur_last", 64'(last_res), 64'(16'h5555));

    // reset in WAIT of entry 2, then a clean run from entry 0
    set_cfg(0, 2, 16'h7777, 7'h04);
    d0 = done_cnt;
    run_seq(0, 2);
    chk("rst_no_done", 64'(done_cnt - d0), 64'(0));
    run_seq(0, -1);
    chk("rst_rerun_cnt", 64'(res_cnt), 64'(4));

    // randomized runs
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < DEPTH; i++) begin
        rom[i]  = 48'({$urandom, $urandom});
        w_a[i]  = $urandom_range(0, 3);
        l_a[i]  = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO);
        rv_a[i] = 16'($urandom);
        fl_a[i] = 7'($urandom);
      end
      run_seq(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? $urandom_range(0, DEPTH-1) : -1);
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fma_op_sequencer.md
# fma_op_sequencer

Operand issuer and result collector for the BF16 FMA datapath. On `start` it walks an external operand table of `DEPTH` entries, presents each {A,B,C} triple to the FMA over a valid/ready handshake, waits for the matching result, and records the result, its exception flags and a sticky flag summary. It sits between the operand ROM and the FMA core inside `top`, driving the FMA the way the simulation bench otherwise would.

## Interface
- `DEPTH`, 8: number of table entries per run (2..256)
- `AW`, 3: table address width, `2**AW >= DEPTH`
- `TIMEOUT`, 15: max cycles spent in WAIT before abort (1..255)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-low reset (0 = reset)
- `start`  in  1  begin a run; sampled only in IDLE
- `tbl_addr`  out  AW  operand table address
- `tbl_data`  in  48  {A[47:32], B[31:16], C[15:0]}, valid one cycle after `tbl_addr`
- `op_valid`  out  1  operand triple valid
- `op_ready`  in  1  FMA accepts operands
- `op_a`, `op_b`, `op_c`  out  16  BF16 operands
- `res_valid`  in  1  FMA result valid (one-cycle pulse)
- `res`  in  16  BF16 result
- `flags`  in  7  {zero, underflow, overflow, qNaN, sNaN, positive_inf, negative_inf}
- `last_res`  out  16  most recent captured result
- `last_flags`  out  7  flags of most recent result
- `flag_accum`  out  7  sticky OR of all flags this run
- `res_cnt`  out  AW+1  results captured this run
- `busy`  out  1  high in any state except IDLE
- `done`  out  1  one-cycle pulse at end of run
- `timeout`  out  1  sticky: run aborted by watchdog

## Operation
- States: IDLE, FETCH, LOAD, ISSUE, WAIT, DONE.
- IDLE: `start`=1 -> clear `flag_accum`, `res_cnt`, `timeout`, index=0 -> FETCH. `start` in other states ignored.
- FETCH: `tbl_addr`=index; -> LOAD.
- LOAD: register `tbl_data` into `op_a/b/c`; -> ISSUE.
- ISSUE: `op_valid`=1, operands held stable; on `op_valid && op_ready` -> WAIT, watchdog cleared.
- WAIT: `op_valid`=0. On `res_valid`: `last_res`<=`res`, `last_flags`<=`flags`, `flag_accum`|=`flags`, `res_cnt`+1; if index==DEPTH-1 -> DONE, else index+1 -> FETCH. Else watchdog+1; watchdog reaching TIMEOUT -> `timeout`=1 -> DONE.
- DONE: `done`=1 one cycle; -> IDLE. `last_*`, `flag_accum`, `res_cnt`, `timeout` hold until next accepted `start`.
- `res_valid` outside WAIT (incl. the handshake cycle) is ignored; at most one result per issued triple.
- `tbl_addr` holds its last value outside FETCH; index never exceeds DEPTH-1 (no wrap).

## Timing
- Reset (`rst`=0, async): state IDLE; all outputs 0 (`tbl_addr`, `op_*`, `op_valid`, `last_res`, `last_flags`, `flag_accum`, `res_cnt`, `busy`, `done`, `timeout`). Reset mid-run aborts immediately; no `done`.
- `start` at edge n -> `busy` at n+1, FETCH at n+1, LOAD n+2, `op_valid` from n+3.
- With `op_ready` held 1 and result latency L cycles after handshake: per-entry period = 3 + L cycles; `done` one cycle after last capture.
- `op_valid` never drops before handshake; `op_a/b/c` unchanged while `op_valid`=1.
- Timeout: `res_valid` absent for TIMEOUT consecutive WAIT cycles -> DONE next cycle.

## Test plan
- DEPTH=4, table {3F80,4000,3F80}x4, `op_ready`=1, result 2 cycles after handshake = 4040 flags 0 -> 4 handshakes, `res_cnt`=4, `last_res`=4040, `flag_accum`=0, `done` pulses once, `busy` low after.
- Backpressure: `op_ready` low 5 cycles in ISSUE -> `op_valid` stays 1, operands stable, single handshake when `op_ready` rises.
- Flags: entry 1 returns overflow (7'b0010000), entry 2 returns qNaN (7'b0001000) -> `flag_accum`=7'b0011000, `last_flags`=last entry's flags.
- Timeout: TIMEOUT=15, no `res_valid` on entry 0 -> `timeout`=1, `done` pulse, `res_cnt`=0; next `start` clears `timeout`.
- Spurious `res_valid` during ISSUE and second pulse in WAIT after capture -> ignored, `res_cnt` increments once per entry.
- `rst` low during WAIT of entry 2 -> all outputs 0 asynchronously, IDLE, no `done`; `start` afterward runs from entry 0.
